mode_switcher_sync: RTL and testbench

- Registered, parametrised successor to the combinational acquisition-mode mux. Routes one of NUM_MODES sources (normal ACQ, S-curve, sweep ACQ, spare) to the shared Microroc slow-control, start/stop and USB FIFO paths.
- Adds a safe mode-change sequence: quiesce the old source, drain its data, then switch. Adds a drain timeout with a sticky error flag.
- Sits between the USB command decoder / test engines and the Microroc SC + USB FIFO interfaces.

---
 rtl/mode_switcher_pkg.sv | 14 +
 rtl/mode_switcher_if.sv | 42 ++++
 rtl/mode_switcher_sync_mux.sv | 20 ++
 rtl/mode_switcher_sync.sv | 151 +++++++++++++++
 tb/tb_mode_switcher_sync.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mode_switcher_pkg.sv
// Shared FSM encoding and mode index constants for the acquisition-mode switcher.
package mode_switcher_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } switchState_t;

    localparam int MODE_ACQ       = 0;
    localparam int MODE_SCURVE    = 1;
    localparam int MODE_SWEEP_ACQ = 2;

endpackage

// File: rtl/mode_switcher_if.sv
// Source-side and sink-side bundle of the mode switcher.
// The master drives mode requests and per-mode sources; the slave (switcher) drives the routed outputs.
interface mode_switcher_if #(
    parameter int NUM_MODES  = 4,
    parameter int NUM_DAC    = 3,
    parameter int DAC_WIDTH  = 10,
    parameter int DATA_WIDTH = 16
);
    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

    logic [MODE_W-1:0]                      ModeSelect;
    logic                                   ErrClear;
    logic [NUM_MODES*NUM_DAC*DAC_WIDTH-1:0] SrcDac;
    logic [NUM_MODES-1:0]                   SrcSCLoad;
    logic [NUM_MODES-1:0]                   SrcStartStop;
    logic [NUM_MODES-1:0]                   SrcDone;
    logic [NUM_MODES*DATA_WIDTH-1:0]        SrcData;
    logic [NUM_MODES-1:0]                   SrcData_en;

    logic [NUM_DAC*DAC_WIDTH-1:0]           OutDac;
    logic                                   OutSCLoad;
    logic [NUM_MODES-1:0]                   OutStartStop;
    logic                                   OutDone;
    logic [DATA_WIDTH-1:0]                  UsbFifoData;
    logic                                   UsbFifoData_en;
    logic [MODE_W-1:0]                      ActiveMode;
    logic                                   SwitchBusy;
    logic                                   DrainTimeoutErr;

    modport master (
        output ModeSelect, ErrClear, SrcDac, SrcSCLoad, SrcStartStop, SrcDone, SrcData, SrcData_en,
        input  OutDac, OutSCLoad, OutStartStop, OutDone, UsbFifoData, UsbFifoData_en,
               ActiveMode, SwitchBusy, DrainTimeoutErr
    );

    modport slave (
        input  ModeSelect, ErrClear, SrcDac, SrcSCLoad, SrcStartStop, SrcDone, SrcData, SrcData_en,
        output OutDac, OutSCLoad, OutStartStop, OutDone, UsbFifoData, UsbFifoData_en,
               ActiveMode, SwitchBusy, DrainTimeoutErr
    );

endinterface

// File: rtl/mode_switcher_sync_mux.sv
// Combinational select of slice [idx] out of a flattened per-mode bus.
module mode_slice_mux #(
    parameter int NUM   = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = 2
) (
    input  logic [NUM*WIDTH-1:0] busIn,
    input  logic [IDX_W-1:0]     idx,
    output logic [WIDTH-1:0]     sliceOut
);

    // Out-of-range indices yield zero rather than aliasing another slice.
    always_comb begin
        sliceOut = '0;
        for (int m = 0; m < NUM; m++) begin
            if (idx == IDX_W'(m)) sliceOut = busIn[m*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mode_switcher_sync.sv
// Registered acquisition-mode switcher: routes one source to the shared SC / start-stop / USB FIFO
// paths and changes source only after the old one has quiesced and drained (or timed out).
module mode_switcher_sync
    import mode_switcher_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int NUM_DAC       = 3,
    parameter int DAC_WIDTH     = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic Clk,
    input  logic reset_n,
    mode_switcher_if.slave bus
);

    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int DACS_W = NUM_DAC * DAC_WIDTH;
    localparam int CNT_W  = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    switchState_t        state, nextState;
    logic [MODE_W-1:0]   activeMode, targetMode;
    logic [CNT_W-1:0]    drainCnt;
    logic                timeoutErr;

    logic [DACS_W-1:0]     selDac;
    logic                  selLoad, selStart, selDone, selDataEn;
    logic [DATA_WIDTH-1:0] selData;

    logic                  modeReq, drainExit, timeoutHit;

    logic [DACS_W-1:0]     dacNxt, dacQ;
    logic                  loadNxt, loadQ, doneNxt, doneQ, dataEnNxt, dataEnQ, busyQ;
    logic [NUM_MODES-1:0]  startNxt, startQ;
    logic [DATA_WIDTH-1:0] dataNxt, dataQ;

    // Per-field source selection, all keyed on the currently routed mode.
    mode_slice_mux #(.NUM(NUM_MODES), .WIDTH(DACS_W), .IDX_W(MODE_W)) uDacMux (
        .busIn(bus.SrcDac), .idx(activeMode), .sliceOut(selDac));
    mode_slice_mux #(.NUM(NUM_MODES), .WIDTH(1), .IDX_W(MODE_W)) uLoadMux (
        .busIn(bus.SrcSCLoad), .idx(activeMode), .sliceOut(selLoad));
    mode_slice_mux #(.NUM(NUM_MODES), .WIDTH(1), .IDX_W(MODE_W)) uStartMux (
        .busIn(bus.SrcStartStop), .idx(activeMode), .sliceOut(selStart));
    mode_slice_mux #(.NUM(NUM_MODES), .WIDTH(1), .IDX_W(MODE_W)) uDoneMux (
        .busIn(bus.SrcDone), .idx(activeMode), .sliceOut(selDone));
    mode_slice_mux #(.NUM(NUM_MODES), .WIDTH(DATA_WIDTH), .IDX_W(MODE_W)) uDataMux (
        .busIn(bus.SrcData), .idx(activeMode), .sliceOut(selData));
    mode_slice_mux #(.NUM(NUM_MODES), .WIDTH(1), .IDX_W(MODE_W)) uDataEnMux (
        .busIn(bus.SrcData_en), .idx(activeMode), .sliceOut(selDataEn));

    // A request is only honoured for an existing mode that differs from the routed one.
    assign modeReq    = (bus.ModeSelect != activeMode) && (32'(bus.ModeSelect) < NUM_MODES);
    assign drainExit  = (state == DRAIN) && (selDone || (drainCnt == CNT_LAST));
    assign timeoutHit = (state == DRAIN) && !selDone && (drainCnt == CNT_LAST);

    // State register plus the mode / drain-counter bookkeeping that moves with it.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ACTIVE;
            activeMode <= MODE_W'(MODE_ACQ);
            targetMode <= MODE_W'(MODE_ACQ);
            drainCnt   <= '0;
        end else begin
            state <= nextState;
            if (state == ACTIVE && modeReq) begin
                targetMode <= bus.ModeSelect;
                drainCnt   <= '0;
            end else if (state == DRAIN) begin
                drainCnt <= drainCnt + 1'b1;
            end
            if (state == SWITCH) activeMode <= targetMode;
        end
    end

    // Next-state logic: the target latched on DRAIN entry is final for this switch.
    always_comb begin
        nextState = state;
        case (state)
            ACTIVE:  if (modeReq) nextState = DRAIN;
            DRAIN:   if (drainExit) nextState = SWITCH;
            SWITCH:  nextState = ACTIVE;
            default: nextState = ACTIVE;
        endcase
    end

    // Sticky timeout flag; a new timeout wins over a simultaneous clear.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)         timeoutErr <= 1'b0;
        else if (timeoutHit)  timeoutErr <= 1'b1;
        else if (bus.ErrClear) timeoutErr <= 1'b0;
    end

    // Output values for the next cycle; start/load/done are cut already on the cycle a switch is detected
    // so the old engine sees its start drop the moment DRAIN begins.
    always_comb begin
        dacNxt    = dacQ;
        loadNxt   = 1'b0;
        startNxt  = '0;
        doneNxt   = 1'b0;
        dataNxt   = selData;
        dataEnNxt = 1'b0;
        case (state)
            ACTIVE: begin
                dacNxt    = selDac;
                dataEnNxt = selDataEn;
                if (!modeReq) begin
                    loadNxt = selLoad;
                    doneNxt = selDone;
                    for (int m = 0; m < NUM_MODES; m++) begin
                        startNxt[m] = selStart && (activeMode == MODE_W'(m));
                    end
                end
            end
            DRAIN:   dataEnNxt = selDataEn;
            default: ;
        endcase
    end

    // Output register stage.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            dacQ    <= '0;
            loadQ   <= 1'b0;
            startQ  <= '0;
            doneQ   <= 1'b0;
            dataQ   <= '0;
            dataEnQ <= 1'b0;
            busyQ   <= 1'b0;
        end else begin
            dacQ    <= dacNxt;
            loadQ   <= loadNxt;
            startQ  <= startNxt;
            doneQ   <= doneNxt;
            dataQ   <= dataNxt;
            dataEnQ <= dataEnNxt;
            busyQ   <= (nextState != ACTIVE);
        end
    end

    assign bus.OutDac          = dacQ;
    assign bus.OutSCLoad       = loadQ;
    assign bus.OutStartStop    = startQ;
    assign bus.OutDone         = doneQ;
    assign bus.UsbFifoData     = dataQ;
    assign bus.UsbFifoData_en  = dataEnQ;
    assign bus.ActiveMode      = activeMode;
    assign bus.SwitchBusy      = busyQ;
    assign bus.DrainTimeoutErr = timeoutErr;

endmodule

// File: tb/tb_mode_switcher_sync.sv
// Randomised and directed bench for mode_switcher_sync against a cycle-level reference model.
module tb_mode_switcher_sync;

    localparam int NM  = 3;
    localparam int ND  = 3;
    localparam int DW  = 10;
    localparam int DTW = 16;
    localparam int TO  = 16;
    localparam int MW  = 2;
    localparam int DS  = ND * DW;
    localparam int SDW = NM * DS;
    localparam int SDD = NM * DTW;

    logic Clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    mode_switcher_if #(.NUM_MODES(NM), .NUM_DAC(ND), .DAC_WIDTH(DW), .DATA_WIDTH(DTW)) bus ();

    mode_switcher_sync #(
        .NUM_MODES(NM), .NUM_DAC(ND), .DAC_WIDTH(DW), .DATA_WIDTH(DTW), .DRAIN_TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .reset_n(reset_n), .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: which mode is routed, what it is doing (0 routing, 1 waiting for done, 2 handing over),
    // and the value every output should show after the next edge.
    int             mMode, mTarget, mPhase, mWaited;
    bit             mErr;
    logic [DS-1:0]  eDac;
    logic           eLoad, eDone, eDataEn, eBusy;
    logic [NM-1:0]  eStart;
    logic [DTW-1:0] eData;

    task automatic model_reset();
        mMode = 0; mTarget = 0; mPhase = 0; mWaited = 0; mErr = 0;
        eDac = '0; eLoad = 0; eDone = 0; eDataEn = 0; eBusy = 0; eStart = '0; eData = '0;
    endtask

    task automatic model_edge();
        int sel;
        bit want, done, tmo;
        sel  = int'(bus.ModeSelect);
        want = (sel < NM) && (sel != mMode);
        done = bus.SrcDone[mMode];
        tmo  = 0;
        eData = bus.SrcData[mMode*DTW +: DTW];
        eLoad = 0; eStart = '0; eDone = 0; eDataEn = 0;
        if (mPhase == 0) begin
            eDac    = bus.SrcDac[mMode*DS +: DS];
            eDataEn = bus.SrcData_en[mMode];
            if (want) begin
                mTarget = sel; mWaited = 0; mPhase = 1;
            end else begin
                eLoad = bus.SrcSCLoad[mMode];
                eStart[mMode] = bus.SrcStartStop[mMode];
                eDone = done;
            end
        end else if (mPhase == 1) begin
            eDataEn = bus.SrcData_en[mMode];
            mWaited++;
            if (done) mPhase = 2;
            else if (mWaited == TO) begin mPhase = 2; tmo = 1; end
        end else begin
            mMode = mTarget; mPhase = 0;
        end
        if (tmo) mErr = 1;
        else if (bus.ErrClear) mErr = 0;
        eBusy = (mPhase != 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus.ModeSelect = '0; bus.ErrClear = 0; bus.SrcDac = '0; bus.SrcSCLoad = '0;
        bus.SrcStartStop = '0; bus.SrcDone = '0; bus.SrcData = '0; bus.SrcData_en = '0;
    endtask

    task automatic rand_sources();
        bus.SrcDac       = SDW'({$urandom(), $urandom(), $urandom()});
        bus.SrcData      = SDD'({$urandom(), $urandom()});
        bus.SrcSCLoad    = NM'($urandom());
        bus.SrcStartStop = NM'($urandom());
        bus.SrcData_en   = NM'($urandom());
    endtask

    task automatic test_reset();
        reset_n = 0;
        model_reset();
        rand_sources();
        bus.ModeSelect = 2'd1; bus.ErrClear = 0; bus.SrcDone = '1;
        #12;
        checks++; if (bus.OutDac !== '0) begin failures++; $display("FAIL reset_dac got=%h exp=0", bus.OutDac); end
        checks++; if (bus.ActiveMode !== '0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", bus.ActiveMode); end
        checks++; if (bus.SwitchBusy !== 0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.SwitchBusy); end
        checks++; if (bus.OutStartStop !== '0) begin failures++; $display("FAIL reset_start got=%b exp=0", bus.OutStartStop); end
        checks++; if ({bus.UsbFifoData_en, bus.UsbFifoData, bus.OutSCLoad, bus.OutDone, bus.DrainTimeoutErr} !== '0) begin
            failures++; $display("FAIL reset_misc got en=%b data=%h load=%b done=%b err=%b exp all 0",
                bus.UsbFifoData_en, bus.UsbFifoData, bus.OutSCLoad, bus.OutDone, bus.DrainTimeoutErr);
        end
        zero_inputs();
        #9;
        reset_n = 1;
    endtask

    task automatic test_dac_route();
        logic [DS-1:0] dac0;
        dac0 = {10'h3FF, 10'h0AA, 10'h155};
        rand_sources();
        bus.SrcDac[DS-1:0] = dac0;
        tick();
        checks++; if (bus.OutDac !== dac0) begin failures++; $display("FAIL dac_route got=%h exp=%h", bus.OutDac, dac0); end
        checks++; if (bus.ActiveMode !== 2'd0) begin failures++; $display("FAIL dac_mode got=%0d exp=0", bus.ActiveMode); end
        checks++; if (bus.SwitchBusy !== 0) begin failures++; $display("FAIL dac_busy got=%b exp=0", bus.SwitchBusy); end
        for (int i = 0; i < 4; i++) begin
            rand_sources();
            tick();
            checks++; if (bus.OutDac !== eDac) begin failures++; $display("FAIL dac_track got=%h exp=%h", bus.OutDac, eDac); end
            checks++; if (bus.OutStartStop !== eStart) begin failures++; $display("FAIL dac_start got=%b exp=%b", bus.OutStartStop, eStart); end
        end
    endtask

    task automatic test_drain_done();
        int busyCnt;
        busyCnt = 0;
        zero_inputs();
        bus.SrcStartStop = 3'b001;
        tick();
        checks++; if (bus.OutStartStop !== 3'b001) begin failures++; $display("FAIL start_active got=%b exp=001", bus.OutStartStop); end
        bus.ModeSelect = 2'd1;
        for (int c = 0; c < 40; c++) begin
            bus.SrcData_en = '0;
            if (c == 1) begin
                bus.SrcData_en = 3'b011;
                bus.SrcData[DTW-1:0] = 16'hBEEF;
                bus.SrcData[2*DTW-1:DTW] = 16'h1111;
            end
            if (c == 2) begin
                bus.SrcData_en = 3'b010;
                bus.SrcData[2*DTW-1:DTW] = 16'h2222;
            end
            if (c == 5) bus.SrcDone[0] = 1'b1;
            tick();
            if (bus.SwitchBusy) busyCnt++;
            checks++; if (bus.OutStartStop !== eStart) begin failures++; $display("FAIL drain_start c=%0d got=%b exp=%b", c, bus.OutStartStop, eStart); end
            checks++; if (bus.UsbFifoData_en !== eDataEn) begin failures++; $display("FAIL drain_en c=%0d got=%b exp=%b", c, bus.UsbFifoData_en, eDataEn); end
            if (c == 0) begin
                checks++; if (bus.OutStartStop !== '0 || bus.SwitchBusy !== 1) begin
                    failures++; $display("FAIL drain_entry got start=%b busy=%b exp start=0 busy=1", bus.OutStartStop, bus.SwitchBusy);
                end
            end
            if (c == 1) begin
                checks++; if (bus.UsbFifoData_en !== 1 || bus.UsbFifoData !== 16'hBEEF) begin
                    failures++; $display("FAIL drain_fwd got en=%b data=%h exp en=1 data=beef", bus.UsbFifoData_en, bus.UsbFifoData);
                end
            end
            if (c == 2) begin
                checks++; if (bus.UsbFifoData_en !== 0) begin failures++; $display("FAIL drain_drop got en=%b exp=0", bus.UsbFifoData_en); end
            end
            if (c > 0 && !bus.SwitchBusy) break;
        end
        checks++; if (busyCnt !== 6) begin failures++; $display("FAIL drain_busy_len got=%0d exp=6", busyCnt); end
        checks++; if (bus.ActiveMode !== 2'd1) begin failures++; $display("FAIL drain_newmode got=%0d exp=1", bus.ActiveMode); end
        checks++; if (bus.DrainTimeoutErr !== 0) begin failures++; $display("FAIL drain_err got=%b exp=0", bus.DrainTimeoutErr); end
        bus.SrcDone = '0;
    endtask

    task automatic test_timeout();
        int busyCnt;
        busyCnt = 0;
        zero_inputs();
        bus.ModeSelect = 2'd0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.SwitchBusy) busyCnt++;
            else if (c > 0) break;
        end
        checks++; if (busyCnt !== TO + 1) begin failures++; $display("FAIL tmo_busy_len got=%0d exp=%0d", busyCnt, TO + 1); end
        checks++; if (bus.DrainTimeoutErr !== 1) begin failures++; $display("FAIL tmo_set got=%b exp=1", bus.DrainTimeoutErr); end
        checks++; if (bus.ActiveMode !== 2'd0) begin failures++; $display("FAIL tmo_mode got=%0d exp=0", bus.ActiveMode); end
        repeat (3) tick();
        checks++; if (bus.DrainTimeoutErr !== 1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", bus.DrainTimeoutErr); end
        bus.ErrClear = 1;
        tick();
        bus.ErrClear = 0;
        checks++; if (bus.DrainTimeoutErr !== 0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", bus.DrainTimeoutErr); end
        // Keep ErrClear high for the whole wait so it coincides with the timeout edge.
        bus.ModeSelect = 2'd1;
        for (int c = 0; c < 60; c++) begin
            bus.ErrClear = (mPhase == 1);
            tick();
            if (c > 0 && !bus.SwitchBusy) break;
        end
        bus.ErrClear = 0;
        checks++; if (bus.DrainTimeoutErr !== 1 || mErr !== 1) begin
            failures++; $display("FAIL tmo_set_wins got=%b exp=1", bus.DrainTimeoutErr);
        end
        bus.ErrClear = 1;
        tick();
        bus.ErrClear = 0;
        checks++; if (bus.DrainTimeoutErr !== 0) begin failures++; $display("FAIL tmo_clear2 got=%b exp=0", bus.DrainTimeoutErr); end
    endtask

    task automatic test_out_of_range();
        bus.ModeSelect = 2'd3;
        for (int i = 0; i < 4; i++) begin
            rand_sources();
            tick();
            checks++; if (bus.SwitchBusy !== 0 || bus.ActiveMode !== 2'd1) begin
                failures++; $display("FAIL oor got busy=%b mode=%0d exp busy=0 mode=1", bus.SwitchBusy, bus.ActiveMode);
            end
        end
        bus.ModeSelect = 2'd1;
    endtask

    task automatic test_retarget();
        int seq[$];
        logic [MW-1:0] prev;
        zero_inputs();
        bus.ModeSelect = 2'd0;
        bus.SrcDone = '1;
        for (int c = 0; c < 10 && bus.ActiveMode != 2'd0; c++) tick();
        tick();
        checks++; if (bus.ActiveMode !== 2'd0) begin failures++; $display("FAIL retarget_start got=%0d exp=0", bus.ActiveMode); end
        bus.SrcDone = '0;
        bus.ModeSelect = 2'd2;
        prev = bus.ActiveMode;
        for (int c = 0; c < 50; c++) begin
            if (c == 1) bus.ModeSelect = 2'd1;
            if (c == 4) bus.SrcDone = '1;
            tick();
            checks++; if (bus.ActiveMode !== MW'(mMode)) begin failures++; $display("FAIL retarget_mode c=%0d got=%0d exp=%0d", c, bus.ActiveMode, mMode); end
            if (bus.ActiveMode != prev) begin seq.push_back(int'(bus.ActiveMode)); prev = bus.ActiveMode; end
            if (c > 4 && !bus.SwitchBusy && bus.ActiveMode == 2'd1) break;
        end
        checks++; if (seq.size() != 2) begin failures++; $display("FAIL retarget_count got=%0d exp=2", seq.size()); end
        else begin
            checks++; if (seq[0] != 2 || seq[1] != 1) begin failures++; $display("FAIL retarget_seq got=%0d,%0d exp=2,1", seq[0], seq[1]); end
        end
        bus.SrcDone = '0;
    endtask

    task automatic test_reset_mid_drain();
        rand_sources();
        bus.SrcDone = '0;
        tick();
        bus.ModeSelect = 2'd0;
        repeat (3) tick();
        checks++; if (bus.SwitchBusy !== 1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", bus.SwitchBusy); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (bus.ActiveMode !== '0 || bus.SwitchBusy !== 0) begin
            failures++; $display("FAIL rst_async got mode=%0d busy=%b exp 0/0", bus.ActiveMode, bus.SwitchBusy);
        end
        checks++; if (bus.OutDac !== '0 || bus.UsbFifoData_en !== 0 || bus.OutStartStop !== '0) begin
            failures++; $display("FAIL rst_async_out got dac=%h en=%b start=%b exp 0", bus.OutDac, bus.UsbFifoData_en, bus.OutStartStop);
        end
        model_reset();
        bus.ModeSelect = 2'd0;
        reset_n = 1;
        tick();
        checks++; if (bus.ActiveMode !== 2'd0 || bus.SwitchBusy !== 0) begin
            failures++; $display("FAIL rst_after got mode=%0d busy=%b exp 0/0", bus.ActiveMode, bus.SwitchBusy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_sources();
            if ($urandom_range(0, 19) == 0) bus.ModeSelect = MW'($urandom_range(0, 3));
            for (int m = 0; m < NM; m++) bus.SrcDone[m] = ($urandom_range(0, 7) == 0);
            bus.ErrClear = ($urandom_range(0, 15) == 0);
            tick();
            checks++; if (bus.OutDac !== eDac) begin failures++; $display("FAIL rnd_dac i=%0d got=%h exp=%h", i, bus.OutDac, eDac); end
            checks++; if (bus.OutSCLoad !== eLoad) begin failures++; $display("FAIL rnd_load i=%0d got=%b exp=%b", i, bus.OutSCLoad, eLoad); end
            checks++; if (bus.OutStartStop !== eStart) begin failures++; $display("FAIL rnd_start i=%0d got=%b exp=%b", i, bus.OutStartStop, eStart); end
            checks++; if (bus.OutDone !== eDone) begin failures++; $display("FAIL rnd_done i=%0d got=%b exp=%b", i, bus.OutDone, eDone); end
            checks++; if (bus.UsbFifoData !== eData) begin failures++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, bus.UsbFifoData, eData); end
            checks++; if (bus.UsbFifoData_en !== eDataEn) begin failures++; $display("FAIL rnd_en i=%0d got=%b exp=%b", i, bus.UsbFifoData_en, eDataEn); end
            checks++; if (bus.ActiveMode !== MW'(mMode)) begin failures++; $display("FAIL rnd_mode i=%0d got=%0d exp=%0d", i, bus.ActiveMode, mMode); end
            checks++; if (bus.SwitchBusy !== eBusy) begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, bus.SwitchBusy, eBusy); end
            checks++; if (bus.DrainTimeoutErr !== mErr) begin failures++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, bus.DrainTimeoutErr, mErr); end
        end
    endtask

    initial begin
        zero_inputs();
        test_reset();
        test_dac_route();
        test_drain_done();
        test_timeout();
        test_out_of_range();
        test_retarget();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
